// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Types and helpers shared by the UART transmit controller and its FIFO.
//   tx_state_t  : controller FSM states.
//   calc_parity : parity bit over one data byte (even or odd).
//   frame_bits  : serial bit periods in one frame (start + 8 data + parity + stop).
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      BITS = 2'd2,
      STOP = 2'd3
   } tx_state_t;

   // Even parity is the XOR of the data bits; odd parity is its complement.
   function automatic logic calc_parity(input logic [7:0] data, input logic odd);
      return odd ? ~^data : ^data;
   endfunction

   function automatic int frame_bits(input int parity_en, input int stop_bits);
      return 9 + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous first-word-fall-through FIFO holding bytes waiting to be sent.
// The head entry is always visible on dout_o; pop_i discards it.
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset (flushes pointers and level)
//   push_i   : write din_i (ignored when full)
//   din_i    : write data
//   pop_i    : discard head entry (ignored when empty)
//   dout_o   : head entry
//   full_o   : level == DEPTH
//   empty_o  : level == 0
//   level_o  : current occupancy
// ---------------------------------------------------------------------------
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW-1:0]    rd_ptr_d;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (level_q == LEVEL_FULL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Depth is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Sequencing controller for the UART transmit shift datapath. Buffers bytes
// from a valid/ready interface, times each serial bit period and tells the
// datapath when to load a frame, shift to the next bit and drive the stop bit.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   s_data     : byte to transmit
//   s_valid    : s_data valid
//   s_ready    : FIFO not full (combinational)
//   dp_load    : pulse, datapath captures dp_frame and starts the start bit
//   dp_frame   : {parity_or_1, data}; meaningful in the dp_load cycle, else 9'h1FF
//   dp_shift   : pulse, datapath advances to the next data/parity bit
//   dp_stop    : pulse, datapath drives the line high for the stop bit(s)
//   frame_done : pulse in the last cycle of the final stop period
//   tx_busy    : controller not idle
//   fifo_level : FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [7:0]                       s_data,
   input  logic                             s_valid,
   output logic                             s_ready,
   output logic                             dp_load,
   output logic [8:0]                       dp_frame,
   output logic                             dp_shift,
   output logic                             dp_stop,
   output logic                             frame_done,
   output logic                             tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

   localparam int LW         = $clog2(FIFO_DEPTH + 1);
   localparam int BW         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int FRAME_BITS = frame_bits(PARITY_EN, STOP_BITS);

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   // frame_done lands one cycle before the final stop period would wrap.
   localparam logic [BW-1:0] BAUD_DONE = BW'(CLKS_PER_BIT - 2);
   // Bit-period boundaries after the start bit: 8 data (+ parity) shifts, then
   // the boundary where bit_q reaches this value becomes the stop strobe.
   localparam logic [3:0]    STOP_IDX  = 4'(FRAME_BITS - STOP_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   tx_state_t      state_q;
   tx_state_t      state_d;
   logic [BW-1:0]  baud_q;
   logic [BW-1:0]  baud_d;
   logic [3:0]     bit_q;
   logic [3:0]     bit_d;
   logic           baud_tick;

   logic           fifo_push;
   logic           fifo_pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [7:0]     fifo_head;
   logic [LW-1:0]  fifo_lvl;
   logic           par_bit;

   // -------------------------------------------------------------------------
   // Byte FIFO
   // -------------------------------------------------------------------------
   assign s_ready   = !fifo_full;
   assign fifo_push = s_valid && s_ready;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8),
      .LW    (LW)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (fifo_push),
      .din_i   (s_data),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_lvl)
   );

   assign fifo_level = fifo_lvl;

   // -------------------------------------------------------------------------
   // Frame word
   // -------------------------------------------------------------------------
   assign par_bit  = (PARITY_EN != 0) ? calc_parity(fifo_head, PARITY_ODD != 0) : 1'b1;
   assign dp_frame = (state_q == LOAD) ? {par_bit, fifo_head} : 9'h1FF;
   assign tx_busy  = (state_q != IDLE);

   // -------------------------------------------------------------------------
   // FSM and counters
   // -------------------------------------------------------------------------
   // The baud counter reads 0 in the cycle after LOAD, so a tick (BAUD_LAST)
   // falls exactly CLKS_PER_BIT cycles after LOAD and every period thereafter.
   assign baud_tick = (baud_q == BAUD_LAST);

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      dp_load    = 1'b0;
      dp_shift   = 1'b0;
      dp_stop    = 1'b0;
      frame_done = 1'b0;
      fifo_pop   = 1'b0;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (!fifo_empty) begin
               state_d = LOAD;
            end
         end

         LOAD: begin
            dp_load  = 1'b1;
            fifo_pop = 1'b1;
            baud_d   = '0;
            bit_d    = '0;
            state_d  = BITS;
         end

         BITS: begin
            baud_d = baud_tick ? '0 : baud_q + 1'b1;
            if (baud_tick) begin
               if (bit_q == STOP_IDX) begin
                  dp_stop = 1'b1;
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  dp_shift = 1'b1;
                  bit_d    = bit_q + 4'd1;
               end
            end
         end

         STOP: begin
            // bit_q now counts completed stop periods, starting from the
            // dp_stop cycle which already used one cycle of the first period.
            baud_d = baud_tick ? '0 : baud_q + 1'b1;
            if (baud_tick) begin
               bit_d = bit_q + 4'd1;
            end
            if ((baud_q == BAUD_DONE) && (bit_q == STOP_LAST)) begin
               frame_done = 1'b1;
               baud_d     = '0;
               bit_d      = '0;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT=4. Four instances cover
// even parity, odd parity, no parity and two stop bits; sel picks which one
// the event logger and the tests observe.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic [3:0] vld    = 4'b0000;
   logic [1:0] sel    = 2'd0;
   int         cyc    = 0;

   logic [3:0] rdy, ld, sh, st, dn, bz;
   logic [8:0] fr [4];
   logic [2:0] lv [4];

   logic       m_ready, m_load, m_shift, m_stop, m_done, m_busy;
   logic [8:0] m_frame;
   logic [2:0] m_level;

   int         load_t [$];
   int         shift_t [$];
   int         stop_t [$];
   int         done_t [$];
   logic [8:0] frame_v [$];
   int         excl_err = 0;

   int         checks   = 0;
   int         failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_ctrl #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(vld[0]), .s_ready(rdy[0]),
      .dp_load(ld[0]), .dp_frame(fr[0]), .dp_shift(sh[0]), .dp_stop(st[0]),
      .frame_done(dn[0]), .tx_busy(bz[0]), .fifo_level(lv[0]));

   uart_tx_ctrl #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(vld[1]), .s_ready(rdy[1]),
      .dp_load(ld[1]), .dp_frame(fr[1]), .dp_shift(sh[1]), .dp_stop(st[1]),
      .frame_done(dn[1]), .tx_busy(bz[1]), .fifo_level(lv[1]));

   uart_tx_ctrl #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_nopar (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(vld[2]), .s_ready(rdy[2]),
      .dp_load(ld[2]), .dp_frame(fr[2]), .dp_shift(sh[2]), .dp_stop(st[2]),
      .frame_done(dn[2]), .tx_busy(bz[2]), .fifo_level(lv[2]));

   uart_tx_ctrl #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(vld[3]), .s_ready(rdy[3]),
      .dp_load(ld[3]), .dp_frame(fr[3]), .dp_shift(sh[3]), .dp_stop(st[3]),
      .frame_done(dn[3]), .tx_busy(bz[3]), .fifo_level(lv[3]));

   assign m_ready = rdy[sel];
   assign m_load  = ld[sel];
   assign m_shift = sh[sel];
   assign m_stop  = st[sel];
   assign m_done  = dn[sel];
   assign m_busy  = bz[sel];
   assign m_frame = fr[sel];
   assign m_level = lv[sel];

   // Event logger for the selected instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (m_load) begin
         load_t.push_back(cyc);
         frame_v.push_back(m_frame);
      end
      if (m_shift) shift_t.push_back(cyc);
      if (m_stop)  stop_t.push_back(cyc);
      if (m_done)  done_t.push_back(cyc);
      if ($countones({m_load, m_shift, m_stop}) > 1) excl_err++;
   end

   task automatic clear_log();
      load_t.delete();
      shift_t.delete();
      stop_t.delete();
      done_t.delete();
      frame_v.delete();
   endtask

   task automatic test_reset();
      sel = 2'd0;
      #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (m_load  !== 1'b0) begin failures++; $display("FAIL reset_dp_load got=%b exp=0", m_load); end
      checks++; if (m_shift !== 1'b0) begin failures++; $display("FAIL reset_dp_shift got=%b exp=0", m_shift); end
      checks++; if (m_stop  !== 1'b0) begin failures++; $display("FAIL reset_dp_stop got=%b exp=0", m_stop); end
      checks++; if (m_done  !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", m_done); end
      checks++; if (m_busy  !== 1'b0) begin failures++; $display("FAIL reset_tx_busy got=%b exp=0", m_busy); end
      checks++; if (m_frame !== 9'h1FF) begin failures++; $display("FAIL reset_dp_frame got=%h exp=1ff", m_frame); end
      checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", m_ready); end
      checks++; if (m_level !== 3'd0) begin failures++; $display("FAIL reset_fifo_level got=%0d exp=0", m_level); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_byte();
      int t0;
      int rel;
      sel = 2'd0;
      clear_log();
      @(negedge clk);
      s_data = 8'hA5; vld[0] = 1'b1; t0 = cyc;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         vld[0] = 1'b0;
         rel = cyc - t0;
         if (rel == 1) begin
            checks++; if (m_level !== 3'd1) begin failures++; $display("FAIL single_level_after_push got=%0d exp=1", m_level); end
            checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL single_busy_before_load got=%b exp=0", m_busy); end
         end
         if (rel == 2) begin
            checks++; if (m_busy !== 1'b1) begin failures++; $display("FAIL single_busy_at_load got=%b exp=1", m_busy); end
         end
         if (rel == 3) begin
            checks++; if (m_level !== 3'd0) begin failures++; $display("FAIL single_level_after_pop got=%0d exp=0", m_level); end
         end
         if (rel == 45) begin
            checks++; if (m_busy !== 1'b1) begin failures++; $display("FAIL single_busy_at_done got=%b exp=1", m_busy); end
         end
         if (rel == 46) begin
            checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL single_busy_after_done got=%b exp=0", m_busy); end
         end
      end
      checks++;
      if (load_t.size() != 1) begin
         failures++; $display("FAIL single_load_count got=%0d exp=1", load_t.size());
      end else begin
         checks++; if (load_t[0] - t0 != 2) begin failures++; $display("FAIL single_load_time got=%0d exp=2", load_t[0] - t0); end
         checks++; if (frame_v[0] !== 9'h0A5) begin failures++; $display("FAIL single_frame got=%h exp=0a5", frame_v[0]); end
      end
      checks++;
      if (shift_t.size() != 9) begin
         failures++; $display("FAIL single_shift_count got=%0d exp=9", shift_t.size());
      end else begin
         for (int k = 0; k < 9; k++) begin
            checks++;
            if (shift_t[k] - t0 != 6 + 4 * k) begin
               failures++; $display("FAIL single_shift_time[%0d] got=%0d exp=%0d", k, shift_t[k] - t0, 6 + 4 * k);
            end
         end
      end
      checks++;
      if (stop_t.size() != 1 || stop_t[0] - t0 != 42) begin
         failures++; $display("FAIL single_stop count=%0d exp_count=1 exp_time=42", stop_t.size());
      end
      checks++;
      if (done_t.size() != 1 || done_t[0] - t0 != 45) begin
         failures++; $display("FAIL single_done count=%0d exp_count=1 exp_time=45", done_t.size());
      end
   endtask

   task automatic test_parity_odd();
      int t0;
      sel = 2'd1;
      clear_log();
      @(negedge clk);
      s_data = 8'h01; vld[1] = 1'b1; t0 = cyc;
      @(negedge clk);
      vld[1] = 1'b0;
      repeat (50) @(negedge clk);
      checks++;
      if (load_t.size() != 1) begin
         failures++; $display("FAIL odd_load_count got=%0d exp=1", load_t.size());
      end else begin
         checks++; if (load_t[0] - t0 != 2) begin failures++; $display("FAIL odd_load_time got=%0d exp=2", load_t[0] - t0); end
         checks++; if (frame_v[0] !== 9'h001) begin failures++; $display("FAIL odd_frame got=%h exp=001", frame_v[0]); end
      end
   endtask

   task automatic test_no_parity();
      int t0;
      sel = 2'd2;
      clear_log();
      @(negedge clk);
      s_data = 8'h01; vld[2] = 1'b1; t0 = cyc;
      @(negedge clk);
      vld[2] = 1'b0;
      repeat (48) @(negedge clk);
      checks++;
      if (frame_v.size() != 1 || frame_v[0] !== 9'h101) begin
         failures++; $display("FAIL nopar_frame count=%0d exp=101", frame_v.size());
      end
      checks++; if (shift_t.size() != 8) begin failures++; $display("FAIL nopar_shift_count got=%0d exp=8", shift_t.size()); end
      checks++;
      if (stop_t.size() != 1 || stop_t[0] - t0 != 38) begin
         failures++; $display("FAIL nopar_stop count=%0d exp_time=38 (L+36)", stop_t.size());
      end
      checks++;
      if (done_t.size() != 1 || done_t[0] - t0 != 41) begin
         failures++; $display("FAIL nopar_done count=%0d exp_time=41", done_t.size());
      end
   endtask

   task automatic test_stop2();
      int t0;
      sel = 2'd3;
      clear_log();
      @(negedge clk);
      s_data = 8'hFF; vld[3] = 1'b1; t0 = cyc;
      @(negedge clk);
      vld[3] = 1'b0;
      repeat (55) @(negedge clk);
      checks++;
      if (frame_v.size() != 1 || frame_v[0] !== 9'h0FF) begin
         failures++; $display("FAIL stop2_frame count=%0d exp=0ff", frame_v.size());
      end
      checks++; if (shift_t.size() != 9) begin failures++; $display("FAIL stop2_shift_count got=%0d exp=9", shift_t.size()); end
      checks++;
      if (stop_t.size() != 1 || stop_t[0] - t0 != 42) begin
         failures++; $display("FAIL stop2_stop count=%0d exp_time=42 (L+40)", stop_t.size());
      end
      checks++;
      if (done_t.size() != 1 || done_t[0] - t0 != 49) begin
         failures++; $display("FAIL stop2_done count=%0d exp_time=49 (L+47)", done_t.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3]   = '{8'h11, 8'h22, 8'h33};
      logic [8:0] exp_fr [3]  = '{9'h011, 9'h022, 9'h033};
      int         exp_lv [3]  = '{2, 1, 0};
      int         lv_after [$];
      logic       was_ld;
      int         t0;
      int         rel;
      sel = 2'd0;
      clear_log();
      was_ld = 1'b0;
      @(negedge clk);
      t0 = cyc;
      for (int i = 0; i < 146; i++) begin
         if (i > 0) @(negedge clk);
         rel = cyc - t0;
         if (rel < 3) begin
            s_data = bytes[rel]; vld[0] = 1'b1;
         end else begin
            vld[0] = 1'b0;
         end
         if (rel == 2) begin
            checks++; if (m_level !== 3'd2) begin failures++; $display("FAIL b2b_level_rel2 got=%0d exp=2", m_level); end
         end
         if (rel == 3) begin
            checks++; if (m_level !== 3'd2) begin failures++; $display("FAIL b2b_level_push_pop got=%0d exp=2", m_level); end
         end
         if (was_ld) lv_after.push_back(int'(m_level));
         was_ld = m_load;
      end
      checks++;
      if (load_t.size() != 3 || done_t.size() != 3) begin
         failures++; $display("FAIL b2b_frame_count loads=%0d dones=%0d exp=3", load_t.size(), done_t.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (frame_v[k] !== exp_fr[k]) begin failures++; $display("FAIL b2b_frame[%0d] got=%h exp=%h", k, frame_v[k], exp_fr[k]); end
         end
         for (int k = 1; k < 3; k++) begin
            checks++;
            if (load_t[k] - done_t[k-1] != 2) begin
               failures++; $display("FAIL b2b_gap[%0d] got=%0d exp=2", k, load_t[k] - done_t[k-1]);
            end
         end
         checks++; if (load_t[0] - t0 != 2) begin failures++; $display("FAIL b2b_first_load got=%0d exp=2", load_t[0] - t0); end
      end
      checks++;
      if (lv_after.size() != 3) begin
         failures++; $display("FAIL b2b_level_samples got=%0d exp=3", lv_after.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (lv_after[k] != exp_lv[k]) begin failures++; $display("FAIL b2b_level_after_load[%0d] got=%0d exp=%0d", k, lv_after[k], exp_lv[k]); end
         end
      end
   endtask

   task automatic test_fifo_full();
      logic [7:0] bytes [6]  = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
      logic [8:0] exp_fr [6] = '{9'h140, 9'h041, 9'h042, 9'h143, 9'h044, 9'h145};
      int         exp_acc [6] = '{0, 1, 2, 3, 4, 48};
      int         acc [6]    = '{-1, -1, -1, -1, -1, -1};
      int         idx;
      int         t0;
      int         rel;
      int         before_done;
      logic       ready5;
      logic [2:0] level5;
      sel = 2'd0;
      clear_log();
      idx = 0;
      ready5 = 1'b1;
      level5 = 3'd0;
      @(negedge clk);
      t0 = cyc;
      for (int i = 0; i < 290; i++) begin
         if (i > 0) @(negedge clk);
         rel = cyc - t0;
         if (rel == 5) begin
            ready5 = m_ready;
            level5 = m_level;
         end
         if (idx < 6) begin
            s_data = bytes[idx]; vld[0] = 1'b1;
            if (m_ready) begin
               acc[idx] = rel;
               idx++;
            end
         end else begin
            vld[0] = 1'b0;
         end
      end
      vld[0] = 1'b0;
      checks++; if (ready5 !== 1'b0) begin failures++; $display("FAIL full_s_ready got=%b exp=0", ready5); end
      checks++; if (level5 !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", level5); end
      checks++; if (idx != 6) begin failures++; $display("FAIL full_accepted got=%0d exp=6", idx); end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (acc[k] != exp_acc[k]) begin failures++; $display("FAIL full_accept_time[%0d] got=%0d exp=%0d", k, acc[k], exp_acc[k]); end
      end
      before_done = 0;
      checks++;
      if (done_t.size() == 0) begin
         failures++; $display("FAIL full_no_frame_done got=0 exp=6");
      end else begin
         for (int k = 0; k < 6; k++) begin
            if (acc[k] >= 0 && acc[k] + t0 < done_t[0]) before_done++;
         end
         checks++; if (before_done != 5) begin failures++; $display("FAIL full_before_done got=%0d exp=5", before_done); end
      end
      checks++;
      if (frame_v.size() != 6) begin
         failures++; $display("FAIL full_frame_count got=%0d exp=6", frame_v.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            checks++;
            if (frame_v[k] !== exp_fr[k]) begin failures++; $display("FAIL full_frame[%0d] got=%h exp=%h", k, frame_v[k], exp_fr[k]); end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int t0;
      int t1;
      sel = 2'd0;
      clear_log();
      @(negedge clk);
      s_data = 8'h77; vld[0] = 1'b1; t0 = cyc;
      @(negedge clk);
      s_data = 8'h78;
      @(negedge clk);
      vld[0] = 1'b0;
      while (cyc - t0 < 19) @(negedge clk);
      checks++; if (m_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", m_busy); end
      checks++; if (m_level !== 3'd1) begin failures++; $display("FAIL midrst_level_before got=%0d exp=1", m_level); end
      reset = 1'b1;
      #1;
      checks++; if (m_load !== 1'b0 || m_shift !== 1'b0 || m_stop !== 1'b0 || m_done !== 1'b0) begin
         failures++; $display("FAIL midrst_strobes got=%b%b%b%b exp=0000", m_load, m_shift, m_stop, m_done);
      end
      checks++; if (m_level !== 3'd0) begin failures++; $display("FAIL midrst_level got=%0d exp=0", m_level); end
      checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", m_busy); end
      checks++; if (m_frame !== 9'h1FF) begin failures++; $display("FAIL midrst_frame got=%h exp=1ff", m_frame); end
      checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", m_ready); end
      clear_log();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      s_data = 8'h5A; vld[0] = 1'b1; t1 = cyc;
      @(negedge clk);
      vld[0] = 1'b0;
      repeat (50) @(negedge clk);
      checks++;
      if (load_t.size() != 1) begin
         failures++; $display("FAIL midrst_load_count got=%0d exp=1", load_t.size());
      end else begin
         checks++; if (load_t[0] - t1 != 2) begin failures++; $display("FAIL midrst_load_time got=%0d exp=2", load_t[0] - t1); end
         checks++; if (frame_v[0] !== 9'h05A) begin failures++; $display("FAIL midrst_frame_after got=%h exp=05a", frame_v[0]); end
      end
      checks++;
      if (done_t.size() != 1 || done_t[0] - t1 != 45) begin
         failures++; $display("FAIL midrst_done count=%0d exp_time=45", done_t.size());
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (excl_err != 0) begin failures++; $display("FAIL strobe_exclusive got=%0d exp=0", excl_err); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_parity_odd();
      test_no_parity();
      test_stop2();
      test_back_to_back();
      test_fifo_full();
      test_reset_mid_frame();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
